// File: rtl/sdram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : sdram_arbiter                                                       |
// | Two-master arbiter in front of a single-transaction SDRAM controller, with  |
// | a read-response watchdog. Define SDRAM_ARB_RR_EN for round-robin arbitration |
// | (default: fixed priority, m0 first).                                         |
// | Rev    : 1.0  initial release                                                |
// +----------------------------------------------------------------------------+
module sdram_arbiter #(
  parameter logic [15:0] RD_TIMEOUT = 16'd64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_valid,
  input  logic        m0_rw,
  input  logic [22:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  output logic        m0_rerr,
  input  logic        m1_valid,
  input  logic        m1_rw,
  input  logic [22:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        m1_rerr,
  output logic [22:0] ctrl_addr,
  output logic        ctrl_rw,
  output logic [31:0] ctrl_wdata,
  output logic        ctrl_in_valid,
  input  logic        ctrl_busy,
  input  logic [31:0] ctrl_rdata,
  input  logic        ctrl_out_valid
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_WAIT_RD = 3'd3,
    S_WAIT_WR = 3'd4
  } state_t;

  localparam logic [31:0] C_ERR_DATA = 32'hDEAD_BEEF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_owner;
  logic [15:0] r_wdog;
  logic        w_grant;
  logic        w_grant_id;
  logic        w_rd_data;
  logic        w_rd_tmo;
  logic        w_rd_done;

`ifdef SDRAM_ARB_RR_EN
  logic        r_last_grant;

  always_comb begin
    w_grant_id = 1'b0;
    if (m0_valid && m1_valid)
      w_grant_id = ~r_last_grant;
    else
      w_grant_id = ~m0_valid;
  end
`else
  always_comb begin
    w_grant_id = ~m0_valid;
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_rd_data   = 1'b0;
    w_rd_tmo    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ctrl_busy && (m0_valid || m1_valid)) begin
          w_grant     = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:  w_state_nxt = S_SETTLE;
      // Controller busy may lag in_valid by a cycle, so it is not trusted here.
      S_SETTLE: w_state_nxt = ctrl_rw ? S_WAIT_WR : S_WAIT_RD;
      S_WAIT_RD: begin
        if (ctrl_out_valid) begin
          w_rd_data   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_wdog == RD_TIMEOUT - 16'd1) begin
          w_rd_tmo    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_WR: begin
        if (!ctrl_busy)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_done = w_rd_data | w_rd_tmo;

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner       <= 1'b0;
      r_wdog        <= '0;
      ctrl_addr     <= '0;
      ctrl_rw       <= 1'b0;
      ctrl_wdata    <= '0;
      ctrl_in_valid <= 1'b0;
      m0_ready      <= 1'b0;
      m1_ready      <= 1'b0;
      m0_rvalid     <= 1'b0;
      m1_rvalid     <= 1'b0;
      m0_rerr       <= 1'b0;
      m1_rerr       <= 1'b0;
      m0_rdata      <= '0;
      m1_rdata      <= '0;
`ifdef SDRAM_ARB_RR_EN
      r_last_grant  <= 1'b1;
`endif
    end else begin
      r_wdog        <= (r_state == S_WAIT_RD) ? r_wdog + 16'd1 : 16'd0;
      ctrl_in_valid <= w_grant;
      m0_ready      <= w_grant & ~w_grant_id;
      m1_ready      <= w_grant &  w_grant_id;
      m0_rvalid     <= w_rd_done & ~r_owner;
      m1_rvalid     <= w_rd_done &  r_owner;
      m0_rerr       <= w_rd_tmo  & ~r_owner;
      m1_rerr       <= w_rd_tmo  &  r_owner;
      if (w_grant) begin
        r_owner    <= w_grant_id;
        ctrl_addr  <= w_grant_id ? m1_addr  : m0_addr;
        ctrl_rw    <= w_grant_id ? m1_rw    : m0_rw;
        ctrl_wdata <= w_grant_id ? m1_wdata : m0_wdata;
`ifdef SDRAM_ARB_RR_EN
        r_last_grant <= w_grant_id;
`endif
      end
      if (w_rd_done && !r_owner)
        m0_rdata <= w_rd_data ? ctrl_rdata : C_ERR_DATA;
      if (w_rd_done && r_owner)
        m1_rdata <= w_rd_data ? ctrl_rdata : C_ERR_DATA;
    end
  end

endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter: RD_TIMEOUT, default 16'd64, read-response watchdog limit in clk cycles (1..65535).
REQ-002 clk  input  1  single clock; all logic on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m0_valid, m1_valid  input  1  request pending; held with stable fields until matching mN_ready.
REQ-005 m0_rw, m1_rw  input  1  1 = write, 0 = read.
REQ-006 m0_addr, m1_addr  input  23  user address.
REQ-007 m0_wdata, m1_wdata  input  32  write data.
REQ-008 m0_ready, m1_ready  output  1  one-cycle accept pulse.
REQ-009 m0_rdata, m1_rdata  output  32  read data; valid only while the matching rvalid is high.
REQ-010 m0_rvalid, m1_rvalid  output  1  one-cycle read-done pulse.
REQ-011 m0_rerr, m1_rerr  output  1  high with rvalid when the read timed out.
REQ-012 ctrl_addr  output  23  to SDRAM controller user_addr.
REQ-013 ctrl_rw  output  1  to controller rw.
REQ-014 ctrl_wdata  output  32  to controller data_in.
REQ-015 ctrl_in_valid  output  1  to controller in_valid.
REQ-016 ctrl_busy  input  1  from controller busy.
REQ-017 ctrl_rdata  input  32  from controller data_out.
REQ-018 ctrl_out_valid  input  1  from controller out_valid.

Function
REQ-019 All outputs SHALL be registered.
REQ-020 FSM states SHALL be IDLE, ISSUE, SETTLE, WAIT_RD, WAIT_WR.
REQ-021 IDLE SHALL pick a winner when ctrl_busy==0 and any mN_valid==1, latch its rw/addr/wdata into ctrl_* and its id into owner, then go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-022 ISSUE SHALL last exactly one cycle, with ctrl_in_valid=1 and the owner's mN_ready=1, then go to SETTLE; request-to-issue latency SHALL be 1 cycle.
REQ-023 SETTLE SHALL last one cycle and ignore ctrl_busy, then go to WAIT_RD for a read or WAIT_WR for a write.
REQ-024 WAIT_WR SHALL return to IDLE on the first cycle with ctrl_busy==0.
REQ-025 In WAIT_RD, ctrl_out_valid==1 SHALL capture ctrl_rdata into the owner's mN_rdata, pulse the owner's mN_rvalid on the next cycle with rerr=0, and return to IDLE.
REQ-026 A watchdog SHALL count WAIT_RD cycles; on reaching RD_TIMEOUT without ctrl_out_valid it SHALL pulse the owner's rvalid with rerr=1 and rdata=32'hDEAD_BEEF, then return to IDLE.
REQ-027 If ctrl_out_valid and the timeout occur in the same cycle, data SHALL win (rerr=0).
REQ-028 ctrl_out_valid seen outside WAIT_RD SHALL be ignored: no rvalid to either master.
REQ-029 ctrl_in_valid, every mN_ready and every mN_rvalid SHALL be zero outside the cases above; the non-owner SHALL never see ready or rvalid.
REQ-030 Only one transaction SHALL be outstanding at a time; a new grant SHALL be evaluated only in IDLE.
REQ-031 The ctrl_addr, ctrl_rw and ctrl_wdata outputs SHALL hold their last issued values until the next grant.

Reset
REQ-032 On rst: state=IDLE; owner=0; last_grant=1; watchdog=0; all ctrl_* outputs, mN_ready, mN_rvalid, mN_rerr and mN_rdata SHALL be 0.
REQ-033 A reset mid-transaction SHALL abandon it with no ready or rvalid pulse; a late controller response SHALL then be dropped per REQ-028.

Configuration
REQ-034 Macro SDRAM_ARB_RR_EN defined: round-robin; when both masters request, grant the one not equal to last_grant, and update last_grant on every grant.
REQ-035 SDRAM_ARB_RR_EN undefined: fixed priority, m0 wins whenever m0_valid==1; last_grant is unused.

Verification
REQ-036 m0 read addr 23'h000400, controller returns 32'h1234_5678 after 6 cycles -> one m0_ready, one m0_rvalid with rdata 32'h1234_5678, rerr=0, m1 outputs 0.
REQ-037 m1 write addr 23'h7FFFFF, data 32'hA5A5_A5A5 -> ctrl_in_valid for exactly 1 cycle with matching addr/rw=1/wdata, m1_ready 1 cycle, FSM back in IDLE once busy falls.
REQ-038 m0 and m1 both hold valid for 4 reads, RR_EN defined -> grants m0,m1,m0,m1; RR_EN undefined -> m0 gets all grants first while it stays valid.
REQ-039 Read with no ctrl_out_valid, RD_TIMEOUT=8 -> owner rvalid=1, rerr=1, rdata=32'hDEAD_BEEF 8 cycles into WAIT_RD; a later stray out_valid produces no pulse.
REQ-040 rst asserted during WAIT_RD, then out_valid arrives -> no rvalid; next request is issued normally.
REQ-041 m0_valid raised while ctrl_busy=1 in IDLE -> no issue until busy=0, then ctrl_in_valid the following cycle.
